// File: rtl/i2c_cfg_sequencer.sv
// I2C configuration sequencer: waits out the power-up delay, writes a table of
// register/data pairs to a fixed slave through an external byte engine with
// per-entry retry, then waits a settle delay and raises DDS_START.
//
// state  | meaning
// -------+--------------------------------------------------------------
// PWRUP  | power-up delay after reset release
// FETCH  | latch table address/data for the current index
// REQ    | wait for engine idle, issue one write request
// WAIT   | wait for completion, NACK or timeout
// GAP    | bus free time before the next request
// SETTLE | all entries written, wait before starting the DDS
// DONE   | DDS_START asserted, held until reset
// ERROR  | retries exhausted, CFG_ERR asserted, no further requests

module i2c_cfg_sequencer #(
    parameter int unsigned POWERUP_DLY = 90000000,
    parameter int unsigned SETTLE_DLY  = 150000000,
    parameter int unsigned GAP_CYC     = 200,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned NUM_REGS    = 11,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h55
) (
    input  logic       clock_in_i,
    input  logic       reset_i,
    output logic [3:0] tbl_idx_o,
    input  logic [7:0] tbl_addr_i,
    input  logic [7:0] tbl_data_i,
    output logic       wr_req_o,
    output logic [6:0] wr_slave_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    input  logic       wr_busy_i,
    input  logic       wr_done_i,
    input  logic       wr_nack_i,
    output logic       cfg_done_o,
    output logic       cfg_err_o,
    output logic       dds_start_o,
    output logic [7:0] status_led_o
);

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Last counter value of each timed state; a delay of 0 still occupies
    // the state for one cycle, so it shares the terminal value of a delay of 1.
    localparam logic [31:0] PWRUP_LAST   = (POWERUP_DLY == 0) ? 32'd0 : 32'(POWERUP_DLY - 1);
    localparam logic [31:0] SETTLE_LAST  = (SETTLE_DLY  == 0) ? 32'd0 : 32'(SETTLE_DLY  - 1);
    localparam logic [31:0] GAP_LAST     = (GAP_CYC     == 0) ? 32'd0 : 32'(GAP_CYC     - 1);
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    // Widened by one bit so NUM_REGS=16 and MAX_RETRY=7 compare without wrap.
    localparam logic [4:0] NUM_REGS_W  = 5'(NUM_REGS);
    localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

    state_t      state_q,    state_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [3:0]  idx_q,      idx_d;
    logic [2:0]  retry_q,    retry_d;
    logic        wr_req_q,   wr_req_d;
    logic [7:0]  addr_q,     addr_d;
    logic [7:0]  data_q,     data_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_err_q,  cfg_err_d;
    logic        dds_q,      dds_d;

    logic [4:0]  idx_next;
    logic [3:0]  retry_next;
    logic        attempt_ok;
    logic        attempt_fail;

    assign idx_next   = {1'b0, idx_q} + 5'd1;
    assign retry_next = {1'b0, retry_q} + 4'd1;

    // WR_NACK is only meaningful alongside WR_DONE; a timeout counts as a NACK.
    assign attempt_ok   = wr_done_i && !wr_nack_i;
    assign attempt_fail = (wr_done_i && wr_nack_i) || (!wr_done_i && (cnt_q == TIMEOUT_LAST));

    // Next-state, counter and datapath decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        idx_d      = idx_q;
        retry_d    = retry_q;
        wr_req_d   = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cfg_done_d = cfg_done_q;
        cfg_err_d  = cfg_err_q;
        dds_d      = dds_q;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                addr_d  = tbl_addr_i;
                data_d  = tbl_data_i;
                state_d = ST_REQ;
            end

            ST_REQ: begin
                if (!wr_busy_i) begin
                    wr_req_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (attempt_ok) begin
                    idx_d   = idx_next[3:0];
                    retry_d = 3'd0;
                    if (idx_next == NUM_REGS_W) begin
                        cfg_done_d = 1'b1;
                        state_d    = ST_SETTLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (attempt_fail) begin
                    retry_d = retry_next[2:0];
                    if (retry_next == MAX_RETRY_W) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_ERROR;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_FETCH;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    dds_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        // Every state entry restarts the shared cycle counter.
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock_in_i) begin
        if (reset_i) begin
            state_q    <= ST_PWRUP;
            cnt_q      <= 32'd0;
            idx_q      <= 4'd0;
            retry_q    <= 3'd0;
            wr_req_q   <= 1'b0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            dds_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            wr_req_q   <= wr_req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cfg_done_q <= cfg_done_d;
            cfg_err_q  <= cfg_err_d;
            dds_q      <= dds_d;
        end
    end

    assign tbl_idx_o    = idx_q;
    assign wr_req_o     = wr_req_q;
    assign wr_slave_o   = SLAVE_ADDR;
    assign wr_addr_o    = addr_q;
    assign wr_data_o    = data_q;
    assign cfg_done_o   = cfg_done_q;
    assign cfg_err_o    = cfg_err_q;
    assign dds_start_o  = dds_q;
    assign status_led_o = {idx_q, cfg_err_q, retry_q};

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: nominal run, single NACK, persistent
// NACK, timeout, busy stall and reset during a transaction.

module tb_i2c_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tbl_idx;
    logic [7:0] tbl_addr;
    logic [7:0] tbl_data;
    logic       wr_req;
    logic [6:0] wr_slave;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       nack;
    logic       cfg_done;
    logic       cfg_err;
    logic       dds_start;
    logic [7:0] status_led;

    logic [7:0] exp_a [3] = '{8'h20, 8'h21, 8'h22};
    logic [7:0] exp_d [3] = '{8'h3C, 8'h5A, 8'h96};

    int cyc    = 0;
    int npulse = 0;
    int n_pass = 0;
    int n_total = 0;
    int base;
    int p0;
    int x0, x1, x2;

    // Free-running clock.
    always #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .POWERUP_DLY (10),
        .SETTLE_DLY  (20),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (50),
        .NUM_REGS    (3),
        .MAX_RETRY   (3),
        .SLAVE_ADDR  (7'h55)
    ) dut (
        .clock_in_i   (clk),
        .reset_i      (rst),
        .tbl_idx_o    (tbl_idx),
        .tbl_addr_i   (tbl_addr),
        .tbl_data_i   (tbl_data),
        .wr_req_o     (wr_req),
        .wr_slave_o   (wr_slave),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_busy_i    (busy),
        .wr_done_i    (done),
        .wr_nack_i    (nack),
        .cfg_done_o   (cfg_done),
        .cfg_err_o    (cfg_err),
        .dds_start_o  (dds_start),
        .status_led_o (status_led)
    );

    // Combinational register table seen by the sequencer.
    always_comb begin
        tbl_addr = 8'hFF;
        tbl_data = 8'hFF;
        if (tbl_idx < 4'd3) begin
            tbl_addr = exp_a[tbl_idx];
            tbl_data = exp_d[tbl_idx];
        end
    end

    // Edge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Count every cycle in which a write request is high.
    always @(negedge clk) if (wr_req === 1'b1) npulse <= npulse + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        nack = 1'b0;
        tick(2);
        chk("rst idx",      32'(tbl_idx),    32'h0);
        chk("rst req",      32'(wr_req),     32'h0);
        chk("rst addr",     32'(wr_addr),    32'h0);
        chk("rst data",     32'(wr_data),    32'h0);
        chk("rst cfg_done", 32'(cfg_done),   32'h0);
        chk("rst cfg_err",  32'(cfg_err),    32'h0);
        chk("rst dds",      32'(dds_start),  32'h0);
        chk("rst led",      32'(status_led), 32'h0);
        chk("rst slave",    32'(wr_slave),   32'h55);
        rst  = 1'b0;
        base = cyc;
        p0   = npulse;
    endtask

    // Wait for a request, check its operands, then respond:
    // mode 0 = ack 8 cycles after the request, 1 = NACK likewise, 2 = no reply.
    task automatic serve(input string tag, input int mode, input int exp_idx, output int pcyc);
        bit found;
        found = 1'b0;
        pcyc  = -1;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (wr_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, " req seen"}, 32'(found), 32'h1);
        if (found) begin
            pcyc = cyc;
            chk({tag, " idx"},   32'(tbl_idx),  32'(exp_idx));
            chk({tag, " addr"},  32'(wr_addr),  32'(exp_a[exp_idx]));
            chk({tag, " data"},  32'(wr_data),  32'(exp_d[exp_idx]));
            tick(1);
            chk({tag, " width"}, 32'(wr_req),   32'h0);
            if (mode != 2) begin
                tick(7);
                done = 1'b1;
                nack = (mode == 1);
                tick(1);
                done = 1'b0;
                nack = 1'b0;
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        nack = 1'b0;

        // Nominal: three acked writes, settle, DDS start.
        do_reset();
        serve("nom e0", 0, 0, x0);
        chk("nom first latency", 32'(x0 - base), 32'd12);
        chk("nom cfg_done early", 32'(cfg_done), 32'h0);
        serve("nom e1", 0, 1, x1);
        chk("nom gap e1", 32'(x1 - x0), 32'd15);
        serve("nom e2", 0, 2, x2);
        chk("nom gap e2", 32'(x2 - x1), 32'd15);
        chk("nom cfg_done", 32'(cfg_done), 32'h1);
        chk("nom idx end", 32'(tbl_idx), 32'h3);
        tick(19);
        chk("nom dds before", 32'(dds_start), 32'h0);
        tick(1);
        chk("nom dds", 32'(dds_start), 32'h1);
        chk("nom led", 32'(status_led), 32'h30);
        chk("nom pulses", 32'(npulse - p0), 32'd3);

        // Single NACK on entry 1.
        do_reset();
        serve("nk1 e0", 0, 0, x0);
        serve("nk1 e1a", 1, 1, x1);
        chk("nk1 led after nack", 32'(status_led), 32'h11);
        serve("nk1 e1b", 0, 1, x2);
        chk("nk1 retry spacing", 32'(x2 - x1), 32'd15);
        chk("nk1 led after ack", 32'(status_led), 32'h20);
        serve("nk1 e2", 0, 2, x0);
        chk("nk1 cfg_done", 32'(cfg_done), 32'h1);
        tick(20);
        chk("nk1 dds", 32'(dds_start), 32'h1);
        chk("nk1 cfg_err", 32'(cfg_err), 32'h0);
        chk("nk1 pulses", 32'(npulse - p0), 32'd4);

        // Persistent NACK on entry 0.
        do_reset();
        serve("pnk a0", 1, 0, x0);
        serve("pnk a1", 1, 0, x1);
        chk("pnk spacing", 32'(x1 - x0), 32'd15);
        chk("pnk err early", 32'(cfg_err), 32'h0);
        serve("pnk a2", 1, 0, x2);
        chk("pnk err", 32'(cfg_err), 32'h1);
        chk("pnk led", 32'(status_led), 32'h0B);
        tick(1000);
        chk("pnk pulses", 32'(npulse - p0), 32'd3);
        chk("pnk dds", 32'(dds_start), 32'h0);
        chk("pnk err hold", 32'(cfg_err), 32'h1);

        // Timeout, with a lone WR_NACK (no WR_DONE) that must be ignored.
        do_reset();
        serve("tmo a0", 2, 0, x0);
        nack = 1'b1;
        tick(5);
        nack = 1'b0;
        serve("tmo a1", 2, 0, x1);
        chk("tmo spacing 1", 32'(x1 - x0), 32'd56);
        serve("tmo a2", 2, 0, x2);
        chk("tmo spacing 2", 32'(x2 - x1), 32'd56);
        tick(48);
        chk("tmo err before", 32'(cfg_err), 32'h0);
        tick(1);
        chk("tmo err", 32'(cfg_err), 32'h1);
        chk("tmo pulses", 32'(npulse - p0), 32'd3);

        // Busy stall: engine busy from reset release for 41 edges.
        busy = 1'b1;
        do_reset();
        tick(41);
        chk("bsy no req", 32'(npulse - p0), 32'd0);
        busy = 1'b0;
        serve("bsy e0", 0, 0, x0);
        chk("bsy latency", 32'(x0 - base), 32'd42);
        tick(3);
        chk("bsy pulses", 32'(npulse - p0), 32'd1);

        // Reset in the middle of entry 2, stray WR_DONE during power-up.
        do_reset();
        serve("rmw e0", 0, 0, x0);
        serve("rmw e1", 0, 1, x1);
        serve("rmw e2", 2, 2, x2);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rmw idx",  32'(tbl_idx),    32'h0);
        chk("rmw addr", 32'(wr_addr),    32'h0);
        chk("rmw led",  32'(status_led), 32'h0);
        chk("rmw req",  32'(wr_req),     32'h0);
        rst  = 1'b0;
        base = cyc;
        p0   = npulse;
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("rmw idx after stray", 32'(tbl_idx), 32'h0);
        serve("rmw r0", 0, 0, x0);
        chk("rmw restart latency", 32'(x0 - base), 32'd12);
        serve("rmw r1", 0, 1, x1);
        serve("rmw r2", 0, 2, x2);
        chk("rmw cfg_done", 32'(cfg_done), 32'h1);
        chk("rmw pulses", 32'(npulse - p0), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_sequencer.md
I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

Interface
REQ-001 Parameter POWERUP_DLY, default 90000000, is the number of cycles from reset release to the first write request.
REQ-002 Parameter SETTLE_DLY, default 150000000, is the number of cycles from the last acknowledged write to DDS_START.
REQ-003 Parameter GAP_CYC, default 200, is the idle cycles enforced between consecutive write requests (bus free time).
REQ-004 Parameter TIMEOUT_CYC, default 100000, is the cycles allowed in WAIT before the transaction is treated as NACK.
REQ-005 Parameter NUM_REGS, default 11, is the table entries to write (1..16).
REQ-006 Parameter MAX_RETRY, default 3, is the attempts per entry before ERROR (1..7).
REQ-007 Parameter SLAVE_ADDR, default 7'h55, is the 7-bit target address.
REQ-008 CLOCK_IN  in  1  the single clock; reset is synchronous and active-high.
REQ-009 RESET  in  1  synchronous, active-high reset.
REQ-010 TBL_IDX  out  4  current table index; TBL_ADDR/TBL_DATA are its combinational lookup.
REQ-011 TBL_ADDR  in  8  register address for TBL_IDX.
REQ-012 TBL_DATA  in  8  register data for TBL_IDX.
REQ-013 WR_REQ  out  1  one-cycle pulse starting one I2C write to the byte engine.
REQ-014 WR_SLAVE  out  7, WR_ADDR out 8, WR_DATA out 8: operands, stable from WR_REQ until WR_DONE.
REQ-015 WR_BUSY  in  1  byte engine is mid-transaction.
REQ-016 WR_DONE  in  1  one-cycle completion pulse from the byte engine.
REQ-017 WR_NACK  in  1  qualifies WR_DONE; meaningful only when WR_DONE=1.
REQ-018 CFG_DONE  out  1, CFG_ERR  out  1, DDS_START  out  1: sticky status flags.
REQ-019 STATUS_LED  out  8  {TBL_IDX, CFG_ERR, retry_cnt[2:0]}.

Function
REQ-020 States: PWRUP, FETCH, REQ, WAIT, GAP, SETTLE, DONE, ERROR.
REQ-021 PWRUP counts POWERUP_DLY cycles, then moves to FETCH.
REQ-022 FETCH registers WR_ADDR/WR_DATA from TBL_ADDR/TBL_DATA in one cycle, then moves to REQ.
REQ-023 REQ waits while WR_BUSY=1, and pulses WR_REQ for exactly one cycle when WR_BUSY=0, then moves to WAIT.
REQ-024 WAIT with WR_DONE=1 and WR_NACK=0 increments TBL_IDX, clears retry_cnt, and goes to SETTLE if the new index equals NUM_REGS, else to GAP.
REQ-025 WAIT with WR_DONE=1 and WR_NACK=1, or with the timer reaching TIMEOUT_CYC, increments retry_cnt, and goes to ERROR if retry_cnt+1 equals MAX_RETRY, else to GAP with the index unchanged.
REQ-026 WR_NACK when WR_DONE=0 shall be ignored, and WR_DONE outside WAIT shall be ignored.
REQ-027 GAP counts GAP_CYC cycles, then moves to FETCH.
REQ-028 SETTLE sets CFG_DONE on entry, counts SETTLE_DLY cycles, then moves to DONE.
REQ-029 DONE asserts DDS_START and holds indefinitely until RESET.
REQ-030 ERROR asserts CFG_ERR, never raises WR_REQ, and DDS_START stays 0.
REQ-031 Exactly one WR_REQ pulse occurs per attempt, so the total pulse count equals NUM_REGS plus the number of retries.
REQ-032 Counters are 32-bit, saturate-free, and reload to 0 on every state entry; a delay parameter of 0 means one cycle in that state.
REQ-033 WR_SLAVE shall be constant SLAVE_ADDR.

Reset
REQ-034 RESET=1 at a clock edge shall force PWRUP, TBL_IDX=0, retry_cnt=0, all counters 0, WR_REQ=0, WR_ADDR=0, WR_DATA=0, CFG_DONE=0, CFG_ERR=0, DDS_START=0, and STATUS_LED=0.
REQ-035 RESET asserted mid-transaction (WAIT) shall abandon it without a further WR_REQ; a subsequent WR_DONE while in PWRUP shall be ignored.

Verification (sim params: POWERUP_DLY=10, SETTLE_DLY=20, GAP_CYC=4, TIMEOUT_CYC=50, NUM_REGS=3, MAX_RETRY=3)
REQ-036 Nominal case: the engine acks every write 8 cycles after WR_REQ -> 3 WR_REQ pulses with (ADDR,DATA) = table entries 0,1,2, the first pulse 12 cycles after reset release, CFG_DONE at the third ack, and DDS_START 20 cycles later.
REQ-037 Single NACK: entry 1 is NACKed once -> entry 1 is re-requested after a 4-cycle gap, TBL_IDX stays 1, total WR_REQ pulses = 4, and the sequence finishes with CFG_ERR=0.
REQ-038 Persistent NACK: entry 0 is always NACKed -> exactly 3 WR_REQ pulses occur, then CFG_ERR=1, DDS_START=0, and no further pulses within 1000 cycles.
REQ-039 Timeout: WR_DONE never arrives -> a retry fires every 50+4+2 cycles, and ERROR is reached after 3 attempts.
REQ-040 Busy stall: WR_BUSY is held at 1 for 30 cycles during REQ -> WR_REQ is delayed until the cycle after WR_BUSY falls, with one pulse only.
REQ-041 Reset mid-WAIT: RESET is pulsed during entry 2 -> all outputs return to their reset values, the sequence restarts from TBL_IDX=0 after 10 cycles, and a stray WR_DONE during PWRUP has no effect.
